// File: rtl/seq_loop_ctrl.sv
// Sequencer for one sequential (non-pipelined) loop around a datapath body.
// It walks pre-loop, per-iteration start/wait/end, early-quit and post-loop phases.
// It exports its state and phase flags, all registered, for a loop monitor.
module seq_loop_ctrl #(
   parameter int unsigned FSM_WIDTH = 3,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] trip_count,
   input  logic                 quit_req,
   input  logic                 body_done,
   output logic                 body_start,
   output logic [CNT_WIDTH-1:0] iter_idx,
   output logic [CNT_WIDTH-1:0] iter_count,
   output logic [FSM_WIDTH-1:0] cur_state,
   output logic                 pre_valid,
   output logic                 iter_start,
   output logic                 iter_end,
   output logic                 loop_quit,
   output logic                 post_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 protocol_err
);

   typedef enum logic [FSM_WIDTH-1:0] {
      StIdle      = FSM_WIDTH'(0),
      StPre       = FSM_WIDTH'(1),
      StIterStart = FSM_WIDTH'(2),
      StIterWait  = FSM_WIDTH'(3),
      StIterEnd   = FSM_WIDTH'(4),
      StPost      = FSM_WIDTH'(5),
      StDone      = FSM_WIDTH'(6)
   } state_e;

   state_e               state_q;
   logic [CNT_WIDTH-1:0] trip_q;
   logic                 quit_q;
   logic                 in_iter;
   logic                 last_iter;

   // quit_req is only honoured while an iteration is in flight
   assign in_iter   = (state_q == StIterStart) || (state_q == StIterWait) ||
                      (state_q == StIterEnd);
   assign last_iter = (iter_idx == trip_q - CNT_WIDTH'(1));
   assign cur_state = state_q;

   // Loop FSM; every flag is registered alongside the state it describes
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         trip_q       <= '0;
         quit_q       <= 1'b0;
         iter_idx     <= '0;
         iter_count   <= '0;
         body_start   <= 1'b0;
         pre_valid    <= 1'b0;
         iter_start   <= 1'b0;
         iter_end     <= 1'b0;
         loop_quit    <= 1'b0;
         post_valid   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         body_start <= 1'b0;
         pre_valid  <= 1'b0;
         iter_start <= 1'b0;
         iter_end   <= 1'b0;
         loop_quit  <= 1'b0;
         post_valid <= 1'b0;
         done       <= 1'b0;

         if (body_done && (state_q != StIterWait)) begin
            protocol_err <= 1'b1;
         end
         if (quit_req && in_iter) begin
            quit_q <= 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (start) begin
                  trip_q     <= trip_count;
                  iter_idx   <= '0;
                  iter_count <= '0;
                  quit_q     <= 1'b0;
                  state_q    <= StPre;
                  pre_valid  <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            StPre: begin
               if (trip_q != '0) begin
                  state_q    <= StIterStart;
                  iter_start <= 1'b1;
                  body_start <= 1'b1;
               end else begin
                  state_q    <= StPost;
                  post_valid <= 1'b1;
               end
            end
            StIterStart: begin
               state_q <= StIterWait;
            end
            StIterWait: begin
               if (body_done) begin
                  state_q  <= StIterEnd;
                  iter_end <= 1'b1;
                  // quit seen in this last wait cycle also counts for the coming ITER_END
                  loop_quit <= (quit_q || quit_req) && !last_iter;
               end
            end
            StIterEnd: begin
               iter_count <= iter_count + CNT_WIDTH'(1);
               if (last_iter || quit_q) begin
                  state_q    <= StPost;
                  post_valid <= 1'b1;
               end else begin
                  iter_idx   <= iter_idx + CNT_WIDTH'(1);
                  state_q    <= StIterStart;
                  iter_start <= 1'b1;
                  body_start <= 1'b1;
               end
            end
            StPost: begin
               state_q <= StDone;
               done    <= 1'b1;
            end
            StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_loop_ctrl.sv
// Self-checking bench for seq_loop_ctrl: each run is scheduled up front from the
// loop timing rules, stimulus is driven open-loop from that schedule, and every
// cycle's outputs are compared with the schedule.
module tb_seq_loop_ctrl;

   localparam int CW = 16;
   localparam int FW = 3;
   localparam int MAXP = 256;

   // flag vector bit layout
   localparam logic [8:0] F_PRE  = 9'b1_0000_0000;
   localparam logic [8:0] F_ITS  = 9'b0_1000_0000;
   localparam logic [8:0] F_ITE  = 9'b0_0100_0000;
   localparam logic [8:0] F_LQ   = 9'b0_0010_0000;
   localparam logic [8:0] F_POST = 9'b0_0001_0000;
   localparam logic [8:0] F_BUSY = 9'b0_0000_1000;
   localparam logic [8:0] F_DONE = 9'b0_0000_0100;
   localparam logic [8:0] F_BS   = 9'b0_0000_0010;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] trip_count;
   logic          quit_req;
   logic          body_done;
   logic          body_start;
   logic [CW-1:0] iter_idx;
   logic [CW-1:0] iter_count;
   logic [FW-1:0] cur_state;
   logic          pre_valid, iter_start, iter_end, loop_quit, post_valid;
   logic          busy, done, protocol_err;

   int n_checks = 0;
   int n_errors = 0;
   int run_id   = 0;
   int wv[16];

   int         e_state[MAXP];
   int         e_idx[MAXP];
   int         e_cnt[MAXP];
   logic [8:0] e_flags[MAXP];
   logic       bd_v[MAXP];
   logic       qr_v[MAXP];

   always #5 clock = ~clock;

   seq_loop_ctrl #(
      .FSM_WIDTH(FW),
      .CNT_WIDTH(CW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .trip_count  (trip_count),
      .quit_req    (quit_req),
      .body_done   (body_done),
      .body_start  (body_start),
      .iter_idx    (iter_idx),
      .iter_count  (iter_count),
      .cur_state   (cur_state),
      .pre_valid   (pre_valid),
      .iter_start  (iter_start),
      .iter_end    (iter_end),
      .loop_quit   (loop_quit),
      .post_valid  (post_valid),
      .busy        (busy),
      .done        (done),
      .protocol_err(protocol_err)
   );

   function automatic logic [8:0] flags_now();
      return {pre_valid, iter_start, iter_end, loop_quit, post_valid, busy, done, body_start,
              protocol_err};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Schedule one run from the timing rules, then drive and check it period by period.
   // Period p is the p-th clock period after the start-accept edge. Entered in an IDLE
   // period; q = iteration that sees a quit (-1 none), q_end puts the quit pulse in
   // that iteration's ITER_END instead of its first ITER_WAIT cycle.
   task automatic do_run(input int n, input int q, input bit q_end, input bit hold);
      int p, e, qe, nexec, last_p;
      bit quit_eff;
      for (int i = 0; i < MAXP; i++) begin
         e_state[i] = 0; e_idx[i] = 0; e_cnt[i] = 0; e_flags[i] = '0;
         bd_v[i] = 1'b0; qr_v[i] = 1'b0;
      end
      qe       = (q < 0) ? 1000 : (q_end ? q + 1 : q);
      nexec    = (qe < n) ? qe + 1 : n;
      quit_eff = (qe < n - 1);

      e_state[1] = 1; e_flags[1] = F_PRE | F_BUSY;
      qr_v[1]    = 1'($urandom % 2);  // quit in PRE must be ignored
      p = 2;
      for (int i = 0; i < nexec; i++) begin
         e_state[p] = 2; e_flags[p] = F_ITS | F_BS | F_BUSY; e_idx[p] = i; e_cnt[p] = i;
         for (int k = 1; k <= wv[i]; k++) begin
            e_state[p+k] = 3; e_flags[p+k] = F_BUSY; e_idx[p+k] = i; e_cnt[p+k] = i;
         end
         bd_v[p+wv[i]] = 1'b1;
         if (q == i && !q_end) qr_v[p+1] = 1'b1;
         e = p + wv[i] + 1;
         e_state[e] = 4; e_idx[e] = i; e_cnt[e] = i;
         e_flags[e] = F_ITE | F_BUSY | ((i == nexec - 1 && quit_eff) ? F_LQ : 9'd0);
         if (q == i && q_end) qr_v[e] = 1'b1;
         p = e + 1;
      end
      for (int k = 0; k < 2; k++) begin
         e_state[p+k] = 5 + k;
         e_idx[p+k]   = (nexec == 0) ? 0 : nexec - 1;
         e_cnt[p+k]   = nexec;
      end
      e_flags[p]   = F_POST | F_BUSY;
      e_flags[p+1] = F_DONE | F_BUSY;
      last_p = p + 1;

      start      = 1'b1;
      trip_count = CW'(n);
      for (int pp = 1; pp <= last_p; pp++) begin
         @(posedge clock);
         #1;
         start      = hold;
         trip_count = hold ? CW'(n) : CW'($urandom);
         body_done  = bd_v[pp];
         quit_req   = qr_v[pp];
         @(negedge clock);
         check_eq($sformatf("run%0d p%0d state", run_id, pp), 64'(cur_state), 64'(e_state[pp]));
         check_eq($sformatf("run%0d p%0d flags", run_id, pp), 64'(flags_now()), 64'(e_flags[pp]));
         check_eq($sformatf("run%0d p%0d idx", run_id, pp), 64'(iter_idx), 64'(e_idx[pp]));
         check_eq($sformatf("run%0d p%0d cnt", run_id, pp), 64'(iter_count), 64'(e_cnt[pp]));
      end
      @(posedge clock);
      #1;
      start     = hold;
      body_done = 1'b0;
      quit_req  = 1'b0;
      @(negedge clock);
      check_eq($sformatf("run%0d idle state", run_id), 64'(cur_state), 64'd0);
      check_eq($sformatf("run%0d idle flags", run_id), 64'(flags_now()), 64'd0);
      run_id++;
   endtask

   initial begin
      int dcnt;
      reset = 1'b0; start = 1'b0; trip_count = '0; quit_req = 1'b0; body_done = 1'b0;
      #2;
      check_eq("reset outputs", {cur_state, iter_idx, iter_count, flags_now()}, 64'd0);
      #20;
      reset = 1'b1;
      @(posedge clock);
      #1;

      // trip=4, body_done every wait cycle
      for (int i = 0; i < 16; i++) wv[i] = 1;
      do_run(4, -1, 1'b0, 1'b0);
      // zero-trip loop
      do_run(0, -1, 1'b0, 1'b0);
      // trip=8, quit during iteration 2's wait
      do_run(8, 2, 1'b0, 1'b0);
      // trip=3, five wait cycles per iteration
      for (int i = 0; i < 16; i++) wv[i] = 5;
      do_run(3, -1, 1'b0, 1'b0);
      // quit in ITER_END of iteration 1: iteration 2 still runs
      for (int i = 0; i < 16; i++) wv[i] = 2;
      do_run(5, 1, 1'b1, 1'b0);
      // quit in the final iteration: no loop_quit
      do_run(3, 2, 1'b0, 1'b0);
      // start held high, trip=2: back-to-back runs
      for (int i = 0; i < 16; i++) wv[i] = 1;
      do_run(2, -1, 1'b0, 1'b1);
      do_run(2, -1, 1'b0, 1'b0);

      // randomized runs
      for (int r = 0; r < 24; r++) begin
         int n, q;
         n = $urandom_range(0, 8);
         for (int i = 0; i < 16; i++) wv[i] = $urandom_range(1, 4);
         q = ($urandom % 3 == 0) ? $urandom_range(0, 8) : -1;
         do_run(n, q, 1'($urandom % 2), 1'b0);
      end

      // body_done in IDLE sets protocol_err
      body_done = 1'b1;
      @(posedge clock);
      #1;
      body_done = 1'b0;
      @(negedge clock);
      check_eq("perr after idle body_done", 64'(protocol_err), 64'd1);
      check_eq("perr state idle", 64'(cur_state), 64'd0);

      // reset in the middle of ITER_WAIT of a trip=5 run
      start      = 1'b1;
      trip_count = CW'(5);
      @(posedge clock);
      #1;
      start = 1'b0;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      check_eq("pre-abort state", 64'(cur_state), 64'd3);
      #1;
      reset = 1'b0;
      #1;
      check_eq("abort outputs", {cur_state, iter_idx, iter_count, flags_now()}, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      dcnt  = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clock);
         if (done) dcnt++;
      end
      check_eq("no done after abort", 64'(dcnt), 64'd0);
      check_eq("idle after abort", {cur_state, iter_idx, iter_count, flags_now()}, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
